// File: rtl/adder_operand_sequencer.sv
// Adder operand sequencer: assembles two N-bit operands from an LSB-first byte
// stream, presents them to an external combinational adder, captures the sum
// and holds it until the consumer accepts it.
// Optional feature macro: ADD_SAT_EN (saturate the captured sum on signed overflow).
module adder_operand_sequencer #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    input  logic         add_of,
    output logic [N-1:0] res_data,
    output logic         res_cout,
    output logic         res_of,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam int unsigned NBYTES = N / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EXEC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [N-1:0]       res_data_q, res_data_d;
    logic               res_cout_q, res_cout_d;
    logic               res_of_q, res_of_d;
    logic               res_valid_q, res_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               byte_xfer;
    logic [N-1:0]       sum_capture;

    // Replace the byte lane selected by idx with b.
    function automatic logic [N-1:0] put_byte(input logic [N-1:0] w,
                                              input logic [CNT_W-1:0] idx,
                                              input logic [7:0] b);
        logic [N-1:0] r;
        r = w;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == CNT_W'(i)) begin
                r[8*i +: 8] = b;
            end
        end
        return r;
    endfunction

    assign byte_xfer = in_valid && in_ready_q;

    // Value captured into res_data at the EXEC edge.
`ifdef ADD_SAT_EN
    logic sat_ovf;
    always_comb begin
        sat_ovf = (a_q[N-1] == b_q[N-1]) && (add_sum[N-1] != a_q[N-1]);
        if (sat_ovf) begin
            sum_capture = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            sum_capture = add_sum;
        end
    end
`else
    always_comb begin
        sum_capture = add_sum;
    end
`endif

    // Next-state, byte placement, result capture and ready decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_of_d    = res_of_q;
        res_valid_d = res_valid_q;

        case (state_q)
            LOAD_A: begin
                if (byte_xfer) begin
                    a_d = put_byte(a_q, cnt_q, in_data);
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (byte_xfer) begin
                    b_d = put_byte(b_q, cnt_q, in_data);
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EXEC: begin
                res_data_d  = sum_capture;
                res_cout_d  = add_cout;
                res_of_d    = add_of;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase

        in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    end

    // State and datapath registers; reset wins over any transfer or handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_of_q    <= 1'b0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_of_q    <= res_of_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign add_in1   = a_q;
    assign add_in2   = b_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign res_of    = res_of_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench for adder_operand_sequencer (N=32). Provides the
// downstream adder, a transaction-level reference model and directed tests.
// Honours ADD_SAT_EN to match the DUT build.
module tb_adder_operand_sequencer;

    localparam int unsigned N  = 32;
    localparam int unsigned NB = N / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] add_in1, add_in2, add_sum;
    logic         add_cout, add_of;
    logic [N-1:0] res_data;
    logic         res_cout, res_of, res_valid;
    logic         res_ready;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Downstream combinational adder.
    assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2};
    assign add_of = (add_in1[N-1] == add_in2[N-1]) && (add_sum[N-1] != add_in1[N-1]);

    adder_operand_sequencer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .add_in1  (add_in1),
        .add_in2  (add_in2),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .add_of   (add_of),
        .res_data (res_data),
        .res_cout (res_cout),
        .res_of   (res_of),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: spec-level arithmetic on whole transactions.
    function automatic logic [N-1:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a + b;
`ifdef ADD_SAT_EN
        if (a[N-1] == b[N-1] && s[N-1] != a[N-1])
            s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        return s;
    endfunction

    function automatic logic ref_cout(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] w;
        w = {1'b0, a} + {1'b0, b};
        return w[N];
    endfunction

    function automatic logic ref_of(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a + b;
        return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    endfunction

    logic [N-1:0] m_a, m_b, m_res;
    logic         m_cout, m_of, m_valid, m_exec;
    int           m_taken;

    // Model: counts accepted bytes; after 2*NB bytes one compute cycle, then hold.
    always @(posedge clk) begin
        if (rst) begin
            m_a <= '0; m_b <= '0; m_res <= '0;
            m_cout <= 1'b0; m_of <= 1'b0; m_valid <= 1'b0; m_exec <= 1'b0;
            m_taken <= 0;
        end else if (m_valid) begin
            if (res_ready) m_valid <= 1'b0;
        end else if (m_exec) begin
            m_res   <= ref_sum(m_a, m_b);
            m_cout  <= ref_cout(m_a, m_b);
            m_of    <= ref_of(m_a, m_b);
            m_valid <= 1'b1;
            m_exec  <= 1'b0;
        end else if (in_valid) begin
            if (m_taken < NB) m_a[8*m_taken +: 8] <= in_data;
            else              m_b[8*(m_taken-NB) +: 8] <= in_data;
            if (m_taken == 2*NB-1) begin
                m_taken <= 0;
                m_exec  <= 1'b1;
            end else begin
                m_taken <= m_taken + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", 64'(in_ready), 64'(!m_exec && !m_valid));
            check("cmp_res_valid", 64'(res_valid), 64'(m_valid));
            check("cmp_add_in1", 64'(add_in1), 64'(m_a));
            check("cmp_add_in2", 64'(add_in2), 64'(m_b));
            if (m_valid) begin
                check("cmp_res_data", 64'(res_data), 64'(m_res));
                check("cmp_res_cout", 64'(res_cout), 64'(m_cout));
                check("cmp_res_of", 64'(res_of), 64'(m_of));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap, inout int cyc);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc++;
        if (gap) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit gap,
                           output int cyc);
        logic [7:0] byt;
        cyc = 0;
        for (int i = 0; i < 2*NB; i++) begin
            byt = (i < NB) ? a[8*i +: 8] : b[8*(i-NB) +: 8];
            send_byte(byt, gap && (i != 2*NB-1), cyc);
        end
    endtask

    // Counts negedges until res_valid; bounded.
    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 40);
        if (!res_valid) check("res_wait_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic release_result();
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("release_res_valid", 64'(res_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_txn(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit gap, input logic [N-1:0] exp_data,
                           output int cyc, output int lat);
        send_op(a, b, gap, cyc);
        wait_result(lat);
        check({name, "_data"}, 64'(res_data), 64'(exp_data));
    endtask

    int cyc, lat, cyc_bb;
    logic [N-1:0] held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_add_in1", 64'(add_in1), 64'd0);
        @(posedge clk); #1;

        // 1 + 2 back-to-back, latency 2 after last byte.
        run_txn("t1", 32'h1, 32'h2, 1'b0, 32'h3, cyc_bb, lat);
        check("t1_latency", 64'(lat), 64'd2);
        check("t1_cycles", 64'(cyc_bb), 64'(2*NB));
        check("t1_cout", 64'(res_cout), 64'd0);
        check("t1_of", 64'(res_of), 64'd0);

        // Hold with res_ready low and stray in_valid pulses.
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_data  = 8'hAA;
            @(negedge clk);
            check("hold_data", 64'(res_data), 64'(held));
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        release_result();
        @(posedge clk); #1;

        // Carry out, no signed overflow, identical with or without saturation.
        run_txn("t2", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, cyc, lat);
        check("t2_cout", 64'(res_cout), 64'd1);
        check("t2_of", 64'(res_of), 64'd0);
        release_result();
        @(posedge clk); #1;

        // Reset after A plus two bytes of B, asserted alongside a byte transfer.
        send_op(32'h1111_1111, 32'h0, 1'b0, cyc); // preload transaction completed before reset
        release_result_guard();
        run_txn("t3", 32'h10, 32'h20, 1'b0, 32'h30, cyc, lat);
        release_result();
        @(posedge clk); #1;

        // Signed overflow cases.
`ifdef ADD_SAT_EN
        run_txn("t4", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h7FFF_FFFF, cyc, lat);
`else
        run_txn("t4", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, cyc, lat);
`endif
        check("t4_of", 64'(res_of), 64'd1);
        release_result();
        @(posedge clk); #1;
`ifdef ADD_SAT_EN
        run_txn("t5", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, cyc, lat);
`else
        run_txn("t5", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, cyc, lat);
`endif
        check("t5_of", 64'(res_of), 64'd1);
        check("t5_cout", 64'(res_cout), 64'd1);
        release_result();
        @(posedge clk); #1;

        // in_valid toggling every cycle: same result, delayed by the gaps.
        run_txn("t6", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, cyc, lat);
        check("t6_cycles", 64'(cyc), 64'(cyc_bb + 2*NB - 1));
        check("t6_latency", 64'(lat), 64'd2);
        release_result();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Completes the pending transaction started just before, so the
    // reset scenario below starts from an idle sequencer.
    task automatic release_result_guard();
        wait_result(lat);
        check("pre_rst_data", 64'(res_data), 64'h1111_1111);
        release_result();
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) send_byte(8'h55, 1'b0, cyc);
        send_byte(8'h66, 1'b0, cyc);
        send_byte(8'h77, 1'b0, cyc);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h88;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_add_in1", 64'(add_in1), 64'd0);
        check("rst_mid_add_in2", 64'(add_in2), 64'd0);
        check("rst_mid_res_data", 64'(res_data), 64'd0);
        check("rst_mid_res_valid", 64'(res_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

endmodule

// File: doc/adder_operand_sequencer.md
ADDER_OPERAND_SEQUENCER -- requirements
Module: adder_operand_sequencer

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits; SHALL be a multiple of 8, >= 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_data  input  8  operand byte stream, LSB byte first.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  sequencer accepts a byte this cycle.
REQ-007 add_in1  output  N  operand A to the downstream adder, driven from internal register.
REQ-008 add_in2  output  N  operand B to the downstream adder, driven from internal register.
REQ-009 add_sum  input  N  adder sum (combinational from add_in1/add_in2).
REQ-010 add_cout  input  1  adder carry out.
REQ-011 add_of  input  1  adder overflow flag.
REQ-012 res_data  output  N  captured result.
REQ-013 res_cout  output  1  captured add_cout.
REQ-014 res_of  output  1  captured add_of.
REQ-015 res_valid  output  1  result held and valid.
REQ-016 res_ready  input  1  consumer accepts result.

Function
REQ-017 FSM states SHALL be LOAD_A, LOAD_B, EXEC, DONE; byte counter cnt ranges 0..N/8-1.
REQ-018 Byte transfer SHALL occur only when in_valid && in_ready; in_valid while in_ready=0 is ignored.
REQ-019 in_ready SHALL be 1 in LOAD_A and LOAD_B, 0 in EXEC and DONE.
REQ-020 LOAD_A: accepted byte written to add_in1[8*cnt+7:8*cnt]; cnt increments; on byte N/8-1 cnt wraps to 0, next state LOAD_B.
REQ-021 LOAD_B: same rule into add_in2; on last byte cnt wraps to 0, next state EXEC.
REQ-022 Gaps in in_valid SHALL stall the counter without state change.
REQ-023 EXEC lasts exactly one cycle; at its closing edge add_sum, add_cout, add_of are registered into res_data, res_cout, res_of; res_valid set to 1; next state DONE.
REQ-024 Latency: res_valid SHALL be high in the second cycle after the cycle in which the last B byte is accepted.
REQ-025 DONE: res_* and add_in1/add_in2 held stable while res_ready=0.
REQ-026 DONE with res_ready=1: res_valid cleared at that edge; next state LOAD_A; in_ready=1 in the following cycle.
REQ-027 Operand registers are fully overwritten by each new load; no clearing between transactions.
REQ-028 res_of SHALL be a pure registered copy of add_of regardless of configuration.

Reset
REQ-029 rst=1 at a clock edge SHALL force state LOAD_A, cnt=0, add_in1=0, add_in2=0, res_data=0, res_cout=0, res_of=0, res_valid=0.
REQ-030 rst in any state, including mid-load or DONE, SHALL discard the partial operand or pending result; no result emitted for it.
REQ-031 rst has priority over a simultaneous byte transfer or result handshake.

Configuration
REQ-032 Macro ADD_SAT_EN: when defined, the EXEC capture SHALL saturate on signed overflow, detected locally as add_in1[N-1]==add_in2[N-1] && add_sum[N-1]!=add_in1[N-1]: res_data = all-ones except MSB (max positive) if add_in1[N-1]=0, else MSB-only (min negative).
REQ-033 Without ADD_SAT_EN, res_data SHALL always equal the captured add_sum; no saturation logic present.

Verification
REQ-034 Bytes 01,00,00,00 then 02,00,00,00 back-to-back -> res_data=0x00000003, res_cout=0, res_of=0, res_valid high 2 cycles after last byte.
REQ-035 A=0xFFFFFFFF, B=0x00000001 -> res_data=0x00000000, res_cout=1, res_of=add_of; identical result with and without ADD_SAT_EN.
REQ-036 Result held with res_ready=0 for 5 cycles -> res_data/res_valid stable, in_ready=0, extra in_valid pulses ignored; res_ready=1 -> res_valid=0 and in_ready=1 next cycle.
REQ-037 rst asserted after 2 bytes of B -> all outputs zero next cycle, state LOAD_A; full new transaction 0x10+0x20 -> res_data=0x00000030.
REQ-038 ADD_SAT_EN defined: A=0x7FFFFFFF, B=0x00000001 -> res_data=0x7FFFFFFF; A=0x80000000, B=0xFFFFFFFF -> res_data=0x80000000; undefined: 0x80000000 and 0x7FFFFFFF respectively.
REQ-039 in_valid toggling 1/0 every cycle during load -> same result as back-to-back, completion delayed by the gap count.
